// File: rtl/argmax_classifier.sv
// Streaming argmax over NUM_CLASSES signed 16-bit scores; reports the winning class
// index and its score with a one-cycle done pulse when the last score is taken.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic             in_valid,
    input  logic [15:0]      in_score,
    output logic             busy,
    output logic [IDX_W-1:0] class_idx,
    output logic [15:0]      max_score,
    output logic             done
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [15:0]      MIN_SCORE = 16'h8000;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [15:0]      best_score_q, best_score_d;
    logic [IDX_W-1:0] class_idx_q, class_idx_d;
    logic [15:0]      max_score_q, max_score_d;
    logic             done_q, done_d;

    logic             take_new;
    logic [IDX_W-1:0] win_idx;
    logic [15:0]      win_score;

    // Winner including the score on the input this cycle; strict '>' keeps the lowest index on ties.
    always_comb begin
        take_new  = (count_q == '0) || ($signed(in_score) > $signed(best_score_q));
        win_idx   = take_new ? count_q  : best_idx_q;
        win_score = take_new ? in_score : best_score_q;
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        class_idx_d  = class_idx_q;
        max_score_d  = max_score_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = COLLECT;
                    count_d      = '0;
                    best_idx_d   = '0;
                    best_score_d = MIN_SCORE;
                end
            end
            COLLECT: begin
                if (start) begin
                    count_d      = '0;
                    best_idx_d   = '0;
                    best_score_d = MIN_SCORE;
                end else if (in_valid) begin
                    best_idx_d   = win_idx;
                    best_score_d = win_score;
                    count_d      = count_q + IDX_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d     = IDLE;
                        count_d     = '0;
                        class_idx_d = win_idx;
                        max_score_d = win_score;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            count_q      <= '0;
            best_idx_q   <= '0;
            best_score_q <= MIN_SCORE;
            class_idx_q  <= '0;
            max_score_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            class_idx_q  <= class_idx_d;
            max_score_q  <= max_score_d;
            done_q       <= done_d;
        end
    end

    assign busy      = (state_q == COLLECT);
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;
    assign done      = done_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: fixed score vectors with hand-computed winners.
module tb_argmax_classifier;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        in_valid;
    logic [15:0] in_score;
    logic        busy;
    logic [3:0]  class_idx;
    logic [15:0] max_score;
    logic        done;

    int checks;
    int failures;

    logic signed [15:0] vec [10];
    logic [3:0]         prev_idx;
    logic [15:0]        prev_score;

    argmax_classifier #(.NUM_CLASSES(10)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .in_valid  (in_valid),
        .in_score  (in_score),
        .busy      (busy),
        .class_idx (class_idx),
        .max_score (max_score),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 16'(busy), 16'd1);
    endtask

    // Sends vec[0..9]; gap_max>0 inserts 1..gap_max idle cycles between scores.
    // Returns in the done cycle with the result checked.
    task automatic collect(input string tag, input int gap_max,
                           input logic [3:0] exp_idx, input logic [15:0] exp_score);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_score = vec[i];
            tick();
            in_valid = 1'b0;
            if (i == 8) begin
                chk({tag, "_done_early"}, 16'(done), 16'd0);
                chk({tag, "_idx_held"}, 16'(class_idx), 16'(prev_idx));
                chk({tag, "_score_held"}, max_score, prev_score);
            end
            if (i < 9 && gap_max > 0) begin
                repeat ($urandom_range(gap_max, 1)) tick();
            end
        end
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_busy_in_done"}, 16'(busy), 16'd0);
        chk({tag, "_class_idx"}, 16'(class_idx), 16'(exp_idx));
        chk({tag, "_max_score"}, max_score, exp_score);
        prev_idx   = exp_idx;
        prev_score = exp_score;
    endtask

    task automatic done_drops(input string tag);
        tick();
        chk({tag, "_done_drop"}, 16'(done), 16'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rstN       = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_score   = '0;
        prev_idx   = '0;
        prev_score = '0;
        #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_idx", 16'(class_idx), 16'd0);
        chk("rst_score", max_score, 16'd0);
        #22 rstN = 1'b1;
        tick();

        // 1: basic back-to-back
        vec = '{16'sd5, 16'sd3, 16'sd9, 16'sd1, 16'sd0, 16'sd2, 16'sd4, 16'sd120, 16'sd7, 16'sd8};
        do_start("t1");
        collect("t1", 0, 4'd7, 16'd120);
        done_drops("t1");

        // 2: ties go to lowest index; all zeros
        vec = '{16'sd0, 16'sd0, 16'sd50, 16'sd0, 16'sd0, 16'sd50, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        do_start("t2a");
        collect("t2a", 0, 4'd2, 16'd50);
        done_drops("t2a");
        vec = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        do_start("t2b");
        collect("t2b", 0, 4'd0, 16'd0);
        done_drops("t2b");

        // 3: signed extremes
        vec = '{-16'sd32768, -16'sd5, -16'sd32768, -16'sd1, -16'sd300,
                -16'sd2, -16'sd7, -16'sd9, -16'sd100, -16'sd32768};
        do_start("t3a");
        collect("t3a", 0, 4'd3, 16'hFFFF);
        done_drops("t3a");
        vec = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd32767};
        do_start("t3b");
        collect("t3b", 0, 4'd9, 16'd32767);
        done_drops("t3b");

        // 4: in_valid pulses while idle, then gapped scores
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_score = 16'd30000;
            tick();
            in_valid = 1'b0;
            tick();
        end
        chk("t4_idle_busy", 16'(busy), 16'd0);
        chk("t4_idle_done", 16'(done), 16'd0);
        vec = '{16'sd100, 16'sd90, 16'sd80, 16'sd70, 16'sd60, 16'sd50, 16'sd40, 16'sd30, 16'sd20, 16'sd10};
        do_start("t4a");
        collect("t4a", 5, 4'd0, 16'd100);
        done_drops("t4a");
        vec = '{16'sd5, 16'sd3, 16'sd9, 16'sd1, 16'sd0, 16'sd2, 16'sd4, 16'sd120, 16'sd7, 16'sd8};
        do_start("t4b");
        collect("t4b", 5, 4'd7, 16'd120);
        done_drops("t4b");

        // 5: restart after 4 scores, with in_valid high on the restart cycle
        do_start("t5");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_score = 16'd9999;
            tick();
        end
        start    = 1'b1;
        in_score = 16'd30000;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy_restart", 16'(busy), 16'd1);
        chk("t5_idx_held_restart", 16'(class_idx), 16'd7);
        vec = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd3};
        collect("t5", 0, 4'd8, 16'd9);
        done_drops("t5");

        // 6: reset mid-collection, then start issued in the done cycle
        do_start("t6");
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_score = 16'd500;
            tick();
        end
        in_valid = 1'b0;
        rstN     = 1'b0;
        #1;
        chk("t6_rst_busy", 16'(busy), 16'd0);
        chk("t6_rst_idx", 16'(class_idx), 16'd0);
        chk("t6_rst_score", max_score, 16'd0);
        tick();
        chk("t6_rst_done", 16'(done), 16'd0);
        #3 rstN = 1'b1;
        tick();
        chk("t6_post_rst_done", 16'(done), 16'd0);
        prev_idx   = '0;
        prev_score = '0;
        vec = '{16'sd3, 16'sd1, 16'sd4, 16'sd1, 16'sd5, 16'sd9, 16'sd2, 16'sd6, 16'sd5, 16'sd3};
        do_start("t6a");
        collect("t6a", 0, 4'd5, 16'd9);
        do_start("t6b");
        chk("t6b_done_drop", 16'(done), 16'd0);
        vec = '{-16'sd4, -16'sd3, -16'sd2, -16'sd1, -16'sd9, -16'sd8, -16'sd7, -16'sd6, -16'sd5, -16'sd10};
        collect("t6b", 0, 4'd3, 16'hFFFF);
        done_drops("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
